// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: FIFO of retired-instruction records for a trace consumer.
// Overflowing records are dropped and counted; the head reads as zero while empty.
module commit_trace_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       update_i,
    input  logic [XLEN-1:0]            pc_i,
    input  logic [XLEN-1:0]            instr_i,
    input  logic [4:0]                 reg_addr_i,
    input  logic [XLEN-1:0]            reg_data_i,
    output logic                       trace_valid_o,
    input  logic                       trace_ready_i,
    output logic [XLEN-1:0]            trace_pc_o,
    output logic [XLEN-1:0]            trace_instr_o,
    output logic [4:0]                 trace_rd_o,
    output logic [XLEN-1:0]            trace_wdata_o,
    output logic                       trace_wen_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic [15:0]                drop_cnt_o,
    output logic                       overflow_o,
    output logic [31:0]                retired_cnt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [4:0]      rd;
        logic [XLEN-1:0] wdata;
        logic            wen;
    } rec_t;

    rec_t          mem_q [DEPTH];
    rec_t          head;
    rec_t          rec_in;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [15:0]   drop_q, drop_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   ret_q, ret_d;
    logic          full, pop, push, drop;

    always_comb begin
        full       = level_q == LW'(DEPTH);
        pop        = level_q != '0 && trace_ready_i;
        // A full buffer still accepts a push when the head leaves on the same edge.
        push       = update_i && (!full || pop);
        drop       = update_i && full && !pop;
        rec_in.wen   = reg_addr_i != 5'd0;
        rec_in.pc    = pc_i;
        rec_in.instr = instr_i;
        rec_in.rd    = rec_in.wen ? reg_addr_i : 5'd0;
        rec_in.wdata = rec_in.wen ? reg_data_i : '0;
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d    = level_q + LW'(push) - LW'(pop);
        drop_d     = drop && drop_q != 16'hFFFF ? drop_q + 16'd1 : drop_q;
        ovf_d      = ovf_q | drop;
        ret_d      = ret_q + 32'(update_i);
        head       = level_q != '0 ? mem_q[rd_ptr_q] : '0;
    end

    always_ff @(posedge clk_i)
        if (push)
            mem_q[wr_ptr_q] <= rec_in;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
            ret_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
            ret_q    <= ret_d;
        end

    assign trace_valid_o = level_q != '0;
    assign trace_pc_o    = head.pc;
    assign trace_instr_o = head.instr;
    assign trace_rd_o    = head.rd;
    assign trace_wdata_o = head.wdata;
    assign trace_wen_o   = head.wen;
    assign level_o       = level_q;
    assign drop_cnt_o    = drop_q;
    assign overflow_o    = ovf_q;
    assign retired_cnt_o = ret_q;
endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb_commit_trace_buffer: directed stimulus with a scoreboard queue of expected head records.
module tb_commit_trace_buffer;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic        wen;
    } rec_t;

    logic        clk_i = 1'b0, rst_i = 1'b1, update_i = 1'b0, trace_ready_i = 1'b0;
    logic [31:0] pc_i = '0, instr_i = '0, reg_data_i = '0;
    logic [4:0]  reg_addr_i = '0;
    logic        trace_valid_o, trace_wen_o, overflow_o;
    logic [31:0] trace_pc_o, trace_instr_o, trace_wdata_o, retired_cnt_o;
    logic [4:0]  trace_rd_o;
    logic [3:0]  level_o;
    logic [15:0] drop_cnt_o;

    int          total = 0, bad = 0, mlevel = 0, mdrop = 0;
    int unsigned mret = 0;
    bit          movf = 0;
    rec_t        sb [$];

    commit_trace_buffer #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .update_i(update_i), .pc_i(pc_i), .instr_i(instr_i),
        .reg_addr_i(reg_addr_i), .reg_data_i(reg_data_i), .trace_valid_o(trace_valid_o),
        .trace_ready_i(trace_ready_i), .trace_pc_o(trace_pc_o), .trace_instr_o(trace_instr_o),
        .trace_rd_o(trace_rd_o), .trace_wdata_o(trace_wdata_o), .trace_wen_o(trace_wen_o),
        .level_o(level_o), .drop_cnt_o(drop_cnt_o), .overflow_o(overflow_o),
        .retired_cnt_o(retired_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: whenever a head is shown it must match the oldest expected record.
    always @(negedge clk_i) begin
        if (trace_valid_o) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL head_unexpected: got pc %0h expected no record", trace_pc_o);
            end else begin
                chk("head", {trace_pc_o, trace_instr_o, trace_rd_o, trace_wdata_o, trace_wen_o}, sb[0]);
                if (trace_ready_i)
                    void'(sb.pop_front());
            end
        end else
            chk("idle_zero", {trace_pc_o, trace_instr_o, trace_rd_o, trace_wdata_o, trace_wen_o}, '0);
    end

    task automatic step(input logic upd, input logic [31:0] pc, input logic [31:0] instr,
                        input logic [4:0] rd, input logic [31:0] data, input logic rdy);
        logic p;
        p = mlevel > 0 && rdy;
        update_i = upd; pc_i = pc; instr_i = instr; reg_addr_i = rd; reg_data_i = data;
        trace_ready_i = rdy;
        if (upd) begin
            mret++;
            if (mlevel < DEPTH || p) begin
                sb.push_back({pc, instr, rd == 0 ? 5'd0 : rd, rd == 0 ? 32'd0 : data, rd != 0});
                mlevel++;
            end else begin
                movf = 1;
                if (mdrop < 65535) mdrop++;
            end
        end
        if (p) mlevel--;
        @(posedge clk_i);
        #1;
        chk("level", level_o, mlevel);
        chk("drop", drop_cnt_o, mdrop);
        chk("ovf", overflow_o, movf);
        chk("retired", retired_cnt_o, mret);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, '0, '0, '0, '0, rdy);
    endtask

    task automatic do_reset();
        rst_i = 1; update_i = 1; trace_ready_i = 1; pc_i = 32'hBAD0BAD0; reg_addr_i = 5'd3;
        sb.delete(); mlevel = 0; mdrop = 0; movf = 0; mret = 0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        update_i = 0; trace_ready_i = 0; rst_i = 0;
        chk("rst_valid", trace_valid_o, 0);
        chk("rst_level", level_o, 0);
        chk("rst_retired", retired_cnt_o, 0);
        chk("rst_drop", drop_cnt_o, 0);
        chk("rst_ovf", overflow_o, 0);
    endtask

    initial begin
        do_reset();
        // single push, held three cycles, then popped
        step(1, 32'h80000000, 32'h00500093, 5'd1, 32'h5, 0);
        chk("one_valid", trace_valid_o, 1);
        chk("one_wen", trace_wen_o, 1);
        chk("one_pc", trace_pc_o, 32'h80000000);
        repeat (3) idle(0);
        chk("held_pc", trace_pc_o, 32'h80000000);
        idle(1);
        chk("popped_level", level_o, 0);
        idle(0);
        // rd=0 record discards data
        step(1, 32'h80000004, 32'h00000013, 5'd0, 32'hDEADBEEF, 0);
        chk("x0_wdata", trace_wdata_o, 0);
        chk("x0_wen", trace_wen_o, 0);
        idle(1);
        idle(0);
        // overflow: 10 pushes into 8 entries
        do_reset();
        for (int i = 0; i < 10; i++)
            step(1, 32'h100 + 32'(4 * i), 32'h13 + 32'(i), 5'(i + 1), 32'(i * 3), 0);
        chk("full_level", level_o, 8);
        chk("full_drop", drop_cnt_o, 2);
        chk("full_ovf", overflow_o, 1);
        chk("full_retired", retired_cnt_o, 10);
        // full with push and pop together
        step(1, 32'h200, 32'h00A00113, 5'd2, 32'hA, 1);
        chk("pp_level", level_o, 8);
        chk("pp_drop", drop_cnt_o, 2);
        chk("pp_head", trace_pc_o, 32'h104);
        repeat (8) idle(1);
        chk("drained", level_o, 0);
        // streaming: pointers wrap
        for (int i = 0; i < 20; i++)
            step(1, 32'h300 + 32'(4 * i), 32'h00100093, 5'd2, 32'(i), 1);
        chk("stream_level", level_o, 1);
        idle(1);
        idle(0);
        // asynchronous reset mid-cycle
        do_reset();
        for (int i = 0; i < 10; i++)
            step(1, 32'h400 + 32'(4 * i), 32'h33, 5'd5, 32'(i), 0);
        repeat (3) idle(1);
        chk("pre_level", level_o, 5);
        chk("pre_ovf", overflow_o, 1);
        trace_ready_i = 0;
        #2;
        rst_i = 1;
        sb.delete(); mlevel = 0; mdrop = 0; movf = 0; mret = 0;
        #1;
        chk("arst_valid", trace_valid_o, 0);
        chk("arst_level", level_o, 0);
        chk("arst_ovf", overflow_o, 0);
        chk("arst_drop", drop_cnt_o, 0);
        chk("arst_retired", retired_cnt_o, 0);
        chk("arst_data", {trace_pc_o, trace_instr_o, trace_rd_o, trace_wdata_o, trace_wen_o}, '0);
        @(posedge clk_i);
        #1;
        rst_i = 0;
        step(1, 32'h500, 32'h00700193, 5'd3, 32'h7, 0);
        chk("after_rst_pc", trace_pc_o, 32'h500);
        idle(1);
        idle(0);
        chk("sb_left", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/commit_trace_buffer.md
COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data/PC width (from riscv_pkg).
REQ-002 SHALL have parameter DEPTH, default 8, meaning record entries; power of two, >= 2.
REQ-003 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port update_i  input  1  core retired one instruction this cycle.
REQ-006 SHALL have port pc_i  input  XLEN  PC of retired instruction.
REQ-007 SHALL have port instr_i  input  XLEN  retired instruction word.
REQ-008 SHALL have port reg_addr_i  input  5  destination register index.
REQ-009 SHALL have port reg_data_i  input  XLEN  destination write data.
REQ-010 SHALL have port trace_valid_o  output  1  head record available.
REQ-011 SHALL have port trace_ready_i  input  1  consumer accepts head record.
REQ-012 SHALL have port trace_pc_o  output  XLEN  head record PC.
REQ-013 SHALL have port trace_instr_o  output  XLEN  head record instruction.
REQ-014 SHALL have port trace_rd_o  output  5  head record register index.
REQ-015 SHALL have port trace_wdata_o  output  XLEN  head record write data.
REQ-016 SHALL have port trace_wen_o  output  1  head record carries a register write.
REQ-017 SHALL have port level_o  output  $clog2(DEPTH)+1  occupied entries.
REQ-018 SHALL have port drop_cnt_o  output  16  records lost to overflow, saturating.
REQ-019 SHALL have port overflow_o  output  1  sticky: at least one record dropped.
REQ-020 SHALL have port retired_cnt_o  output  32  total update_i pulses seen, wrapping.

Function
REQ-021 SHALL capture a record when update_i=1: {pc_i, instr_i, reg_addr_i, reg_data_i, wen}.
REQ-022 SHALL set wen=1 iff reg_addr_i!=0; when reg_addr_i==0, store rd=0 and wdata=0 regardless of reg_data_i.
REQ-023 SHALL be a synchronous FIFO with registered pointers; record written at edge N is visible on outputs (trace_valid_o=1) at N+1 (one-cycle latency, no bypass).
REQ-024 SHALL pop the head on an edge where trace_valid_o=1 and trace_ready_i=1; trace_ready_i while empty has no effect.
REQ-025 SHALL hold all trace_*_o outputs stable while trace_valid_o=1 and trace_ready_i=0.
REQ-026 SHALL drive trace_pc_o/instr_o/rd_o/wdata_o/wen_o to 0 when empty.
REQ-027 SHALL, when full with simultaneous push and pop, accept the push (level stays DEPTH, no drop).
REQ-028 SHALL, when full and push without pop, discard the new record, increment drop_cnt_o (saturate at 0xFFFF) and set overflow_o.
REQ-029 SHALL, when empty with simultaneous push, not pop (push only, level becomes 1).
REQ-030 SHALL wrap read/write pointers modulo DEPTH; level_o ranges 0..DEPTH exactly.
REQ-031 SHALL increment retired_cnt_o on every update_i=1, dropped or not, wrapping 0xFFFFFFFF->0.
REQ-032 SHALL preserve record order: output sequence equals accepted input sequence.

Reset
REQ-033 SHALL, on rst_i=1 (asynchronous, any cycle incl. mid-transfer), clear pointers, level_o=0, trace_valid_o=0, all trace data outputs=0, drop_cnt_o=0, overflow_o=0, retired_cnt_o=0.
REQ-034 SHALL ignore update_i and trace_ready_i while rst_i=1; first capture on first rising edge after rst_i deasserts.
REQ-035 SHALL not require storage array contents to be reset; only observable outputs are defined.

Verification
REQ-036 Reset then single push pc=0x80000000, instr=0x00500093, rd=1, data=0x5, ready=0 -> next cycle valid=1, wen=1, level=1; outputs held 3 cycles; ready=1 pops, level=0, outputs 0.
REQ-037 Push instr=0x00000013 with rd=0, data=0xDEADBEEF -> record rd=0, wdata=0, wen=0.
REQ-038 ready=0, 10 consecutive pushes (DEPTH=8) -> level=8, drop_cnt=2, overflow=1, retired_cnt=10; draining yields the first 8 PCs in order.
REQ-039 Full buffer, push+pop same cycle -> level stays 8, drop_cnt unchanged, new record appears last.
REQ-040 Continuous push with ready=1 for 20 cycles -> level toggles 0/1 never higher, 20 records out in order, pointers wrap twice without loss.
REQ-041 Assert rst_i asynchronously mid-cycle with level=5, overflow=1 -> all outputs zero immediately, before next clock edge.
